// File: rtl/memory_arbiter.sv
// memory_arbiter
//
// Shares one single-ported memory between two requesters:
//   port 0 - instruction fetch
//   port 1 - load/store or loader
// At most one transaction is granted per cycle. The memory request signals
// are driven combinationally from the granted port. Responses come back one
// cycle later and are steered to the port that owned the transaction.
//
// Optional feature macro: MEMORY_ARBITER_ROUND_ROBIN_EN
//   undefined : fixed priority, port 1 wins ties, port 0 protected by a
//               starvation counter (forced win once wait count hits MAX_WAIT)
//   defined   : 1-bit round-robin pointer decides ties; the starvation
//               counter is still present as a backstop
//
// Parameters:
//   MAX_WAIT   consecutive denied cycles of port 0 before it is forced (1..255)
//
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   reqN_valid/write/address/wdata/mask   request from port N (inputs)
//   reqN_ready                      grant for port N
//   respN_valid, respN_rdata        response for port N (rdata = memory data)
//   read_memory_data                registered read data from memory
//   read_memory_address, write_memory_address, write_memory_data,
//   write_memory_mask, memory_write_enable   memory request (0 when idle)

module memory_arbiter #(
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [31:0] req0_address,
    input  logic [31:0] req0_wdata,
    input  logic [31:0] req0_mask,
    output logic        req0_ready,
    output logic        resp0_valid,
    output logic [31:0] resp0_rdata,

    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [31:0] req1_address,
    input  logic [31:0] req1_wdata,
    input  logic [31:0] req1_mask,
    output logic        req1_ready,
    output logic        resp1_valid,
    output logic [31:0] resp1_rdata,

    input  logic [31:0] read_memory_data,
    output logic [31:0] read_memory_address,
    output logic [31:0] write_memory_address,
    output logic [31:0] write_memory_data,
    output logic [31:0] write_memory_mask,
    output logic        memory_write_enable
);

    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    logic [7:0] r_wait_cnt;
    logic       r_resp_pending;
    logic       r_resp_owner;

    logic       w_force0;
    logic       w_tie_to1;
    logic       w_grant0;
    logic       w_grant1;
    logic       w_accept;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [31:0] w_mask;
    logic       w_we;

    assign w_force0 = (r_wait_cnt == LP_MAX_WAIT);

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    // Pointer names the port that wins the next tie; reset favours port 0.
    logic r_prio;

    assign w_tie_to1 = r_prio;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prio <= 1'b0;
        end else if (w_accept) begin
            // Point at whichever port did not get this grant.
            r_prio <= w_grant0;
        end
    end
`else
    assign w_tie_to1 = 1'b1;
`endif

    // Grants are gated by reset_n so nothing is handed out while in reset.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (reset_n) begin
            if (req0_valid && req1_valid) begin
                if (w_force0 || !w_tie_to1) begin
                    w_grant0 = 1'b1;
                end else begin
                    w_grant1 = 1'b1;
                end
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
        end
    end

    assign w_accept   = w_grant0 | w_grant1;
    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    // Idle drives zeros: memory performs a harmless read of address 0.
    always_comb begin
        w_addr  = 32'd0;
        w_wdata = 32'd0;
        w_mask  = 32'd0;
        w_we    = 1'b0;
        if (w_grant0) begin
            w_addr = req0_address;
            w_we   = req0_write;
            if (req0_write) begin
                w_wdata = req0_wdata;
                w_mask  = req0_mask;
            end
        end else if (w_grant1) begin
            w_addr = req1_address;
            w_we   = req1_write;
            if (req1_write) begin
                w_wdata = req1_wdata;
                w_mask  = req1_mask;
            end
        end
    end

    assign read_memory_address  = w_addr;
    assign write_memory_address = w_addr;
    assign write_memory_data    = w_wdata;
    assign write_memory_mask    = w_mask;
    assign memory_write_enable  = w_we;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= 8'd0;
        end else if (req0_valid && !w_grant0) begin
            if (r_wait_cnt >= LP_MAX_WAIT) begin
                r_wait_cnt <= LP_MAX_WAIT;
            end else begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end else begin
            r_wait_cnt <= 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_resp_pending <= 1'b0;
            r_resp_owner   <= 1'b0;
        end else begin
            r_resp_pending <= w_accept;
            if (w_accept) begin
                r_resp_owner <= w_grant1;
            end
        end
    end

    assign resp0_valid = r_resp_pending && !r_resp_owner;
    assign resp1_valid = r_resp_pending &&  r_resp_owner;

    // Memory is registered, so its output already lines up with the response.
    assign resp0_rdata = read_memory_data;
    assign resp1_rdata = read_memory_data;

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

    logic        clk;
    logic        reset_n;
    logic        req0_valid, req0_write, req1_valid, req1_write;
    logic [31:0] req0_address, req0_wdata, req0_mask;
    logic [31:0] req1_address, req1_wdata, req1_mask;
    logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
    logic [31:0] resp0_rdata, resp1_rdata;
    logic [31:0] read_memory_data;
    logic [31:0] read_memory_address, write_memory_address;
    logic [31:0] write_memory_data, write_memory_mask;
    logic        memory_write_enable;

    int checks;
    int failures;

    logic [31:0] mem [256];

    memory_arbiter #(.MAX_WAIT(3)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .req0_valid           (req0_valid),
        .req0_write           (req0_write),
        .req0_address         (req0_address),
        .req0_wdata           (req0_wdata),
        .req0_mask            (req0_mask),
        .req0_ready           (req0_ready),
        .resp0_valid          (resp0_valid),
        .resp0_rdata          (resp0_rdata),
        .req1_valid           (req1_valid),
        .req1_write           (req1_write),
        .req1_address         (req1_address),
        .req1_wdata           (req1_wdata),
        .req1_mask            (req1_mask),
        .req1_ready           (req1_ready),
        .resp1_valid          (resp1_valid),
        .resp1_rdata          (resp1_rdata),
        .read_memory_data     (read_memory_data),
        .read_memory_address  (read_memory_address),
        .write_memory_address (write_memory_address),
        .write_memory_data    (write_memory_data),
        .write_memory_mask    (write_memory_mask),
        .memory_write_enable  (memory_write_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port memory: registered read returns pre-write data.
    always @(posedge clk) begin
        read_memory_data <= mem[read_memory_address[9:2]];
        if (memory_write_enable) begin
            mem[write_memory_address[9:2]] <=
                (mem[write_memory_address[9:2]] & ~write_memory_mask) |
                (write_memory_data & write_memory_mask);
        end
    end

    typedef struct {
        logic        v0, w0;
        logic [31:0] a0, d0, m0;
        logic        v1, w1;
        logic [31:0] a1, d1, m1;
        logic        e_rdy0, e_rdy1, e_we;
        logic [31:0] e_addr, e_wd, e_mask;
        logic        e_rsp0, e_rsp1, chk_rd;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(
        input logic v0, input logic w0, input logic [31:0] a0,
        input logic [31:0] d0, input logic [31:0] m0,
        input logic v1, input logic w1, input logic [31:0] a1,
        input logic [31:0] d1, input logic [31:0] m1,
        input logic e_rdy0, input logic e_rdy1, input logic e_we,
        input logic [31:0] e_addr, input logic [31:0] e_wd,
        input logic [31:0] e_mask, input logic e_rsp0, input logic e_rsp1,
        input logic chk_rd, input logic [31:0] e_rd);
        vec_t v;
        v.v0 = v0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.m0 = m0;
        v.v1 = v1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.m1 = m1;
        v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1; v.e_we = e_we;
        v.e_addr = e_addr; v.e_wd = e_wd; v.e_mask = e_mask;
        v.e_rsp0 = e_rsp0; v.e_rsp1 = e_rsp1; v.chk_rd = chk_rd; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        req0_valid = v.v0; req0_write = v.w0; req0_address = v.a0;
        req0_wdata = v.d0; req0_mask = v.m0;
        req1_valid = v.v1; req1_write = v.w1; req1_address = v.a1;
        req1_wdata = v.d1; req1_mask = v.m1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_write = 0; req0_address = 0; req0_wdata = 0; req0_mask = 0;
        req1_valid = 0; req1_write = 0; req1_address = 0; req1_wdata = 0; req1_mask = 0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".rdy0"}, {31'd0, req0_ready}, 32'd0);
        chk({tag, ".rdy1"}, {31'd0, req1_ready}, 32'd0);
        chk({tag, ".we"}, {31'd0, memory_write_enable}, 32'd0);
        chk({tag, ".raddr"}, read_memory_address, 32'd0);
        chk({tag, ".waddr"}, write_memory_address, 32'd0);
        chk({tag, ".wdata"}, write_memory_data, 32'd0);
        chk({tag, ".wmask"}, write_memory_mask, 32'd0);
        chk({tag, ".rsp0"}, {31'd0, resp0_valid}, 32'd0);
        chk({tag, ".rsp1"}, {31'd0, resp1_valid}, 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        mem[0] = 32'h0000_0013;
        for (int i = 1; i < 256; i++) mem[i] = 32'h1111_0000 | 32'(i);
        idle_inputs();

        // fields: v0 w0 a0 d0 m0 | v1 w1 a1 d1 m1 | rdy0 rdy1 we addr wd mask | rsp0 rsp1 chk rd
        vecs[0] = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0);
        vecs[1] = mk(1,0,32'h8000_0000,32'h1234,32'hFFFF, 0,0,0,0,0,
                     1,0,0,32'h8000_0000,0,0, 0,0,0,0);
        vecs[2] = mk(0,0,0,0,0, 1,1,32'h8000_0100,32'hDEAD_BEEF,32'hFFFF_FFFF,
                     0,1,1,32'h8000_0100,32'hDEAD_BEEF,32'hFFFF_FFFF, 1,0,1,32'h0000_0013);
        vecs[3] = mk(0,0,0,0,0, 1,0,32'h8000_0100,32'hDEAD_BEEF,32'hFFFF_FFFF,
                     0,1,0,32'h8000_0100,0,0, 0,1,0,0);
        vecs[4] = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 0,1,1,32'hDEAD_BEEF);
        vecs[5] = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0);
        vecs[6] = mk(0,0,0,0,0, 1,1,32'h8000_0104,32'hAABB_CCDD,32'h0000_FFFF,
                     0,1,1,32'h8000_0104,32'hAABB_CCDD,32'h0000_FFFF, 0,0,0,0);
        vecs[7] = mk(0,0,0,0,0, 1,0,32'h8000_0104,0,0,
                     0,1,0,32'h8000_0104,0,0, 0,1,0,0);
        vecs[8] = mk(1,0,32'h8000_0008,0,0, 0,0,0,0,0,
                     1,0,0,32'h8000_0008,0,0, 0,1,1,32'h1111_CCDD);
        vecs[9] = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 1,0,1,32'h1111_0002);

        // Reset state.
        reset_n = 1'b0;
        #2;
        chk_idle_outputs("reset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("v%0d.rdy0", i), {31'd0, req0_ready}, {31'd0, vecs[i].e_rdy0});
            chk($sformatf("v%0d.rdy1", i), {31'd0, req1_ready}, {31'd0, vecs[i].e_rdy1});
            chk($sformatf("v%0d.we", i), {31'd0, memory_write_enable}, {31'd0, vecs[i].e_we});
            chk($sformatf("v%0d.raddr", i), read_memory_address, vecs[i].e_addr);
            chk($sformatf("v%0d.waddr", i), write_memory_address, vecs[i].e_addr);
            chk($sformatf("v%0d.wdata", i), write_memory_data, vecs[i].e_wd);
            chk($sformatf("v%0d.wmask", i), write_memory_mask, vecs[i].e_mask);
            chk($sformatf("v%0d.rsp0", i), {31'd0, resp0_valid}, {31'd0, vecs[i].e_rsp0});
            chk($sformatf("v%0d.rsp1", i), {31'd0, resp1_valid}, {31'd0, vecs[i].e_rsp1});
            if (vecs[i].chk_rd) begin
                if (vecs[i].e_rsp0)
                    chk($sformatf("v%0d.rdata0", i), resp0_rdata, vecs[i].e_rd);
                else
                    chk($sformatf("v%0d.rdata1", i), resp1_rdata, vecs[i].e_rd);
            end
            @(posedge clk);
            #1;
        end

        // Both ports continuously valid from a fresh reset.
        idle_inputs();
        do_reset();
        req0_valid = 1; req0_address = 32'h8000_0000;
        req1_valid = 1; req1_address = 32'h8000_0004;
        for (int i = 0; i < 8; i++) begin
            logic exp_port;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            exp_port = (i % 2) != 0;
`else
            exp_port = (i % 4) != 3;
`endif
            @(negedge clk);
            chk($sformatf("both%0d.rdy0", i), {31'd0, req0_ready}, {31'd0, ~exp_port});
            chk($sformatf("both%0d.rdy1", i), {31'd0, req1_ready}, {31'd0, exp_port});
            chk($sformatf("both%0d.addr", i), read_memory_address,
                exp_port ? 32'h8000_0004 : 32'h8000_0000);
            @(posedge clk);
            #1;
        end

        // Read accepted, then reset asserted in the following cycle.
        idle_inputs();
        @(posedge clk);
        #1;
        req0_valid = 1; req0_address = 32'h8000_0000;
        @(negedge clk);
        chk("rstmid.rdy0", {31'd0, req0_ready}, 32'd1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        req1_valid = 1; req1_write = 1; req1_address = 32'h8000_0010;
        req1_wdata = 32'h5555_5555; req1_mask = 32'hFFFF_FFFF;
        @(negedge clk);
        chk_idle_outputs("inrst");
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_idle_outputs($sformatf("postrst%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the single-ported `memory` block between two requesters: port 0 (instruction fetch) and port 1 (load/store or loader). It grants at most one transaction per cycle and drives the memory request signals combinationally from the granted port. It routes each 1-cycle read (or write acknowledge) back to its owner, and prevents port 0 starvation with a wait counter. It sits between `core` (or core plus loader) and `memory` inside `sim`.

## Interface
Parameters:
- `MAX_WAIT`, default 8: consecutive denied cycles of port 0 after which port 0 is forced to win; legal range 1..255.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1  request present.
- `req0_write`, `req1_write`  in  1  1 = write, 0 = read.
- `req0_address`, `req1_address`  in  32  byte address, passed unmodified.
- `req0_wdata`, `req1_wdata`  in  32  write data.
- `req0_mask`, `req1_mask`  in  32  write bit mask.
- `req0_ready`, `req1_ready`  out  1  grant; transaction accepted this cycle when valid && ready.
- `resp0_valid`, `resp1_valid`  out  1  response for a transaction accepted in the previous cycle.
- `resp0_rdata`, `resp1_rdata`  out  32  read data; equals `read_memory_data`.
- `read_memory_data`  in  32  from memory; registered by memory.
- `read_memory_address`, `write_memory_address`  out  32  granted address, or 0 when idle.
- `write_memory_data`, `write_memory_mask`  out  32  granted wdata and mask, or 0 when idle or reading.
- `memory_write_enable`  out  1  granted write.

## Operation
- Grant is combinational each cycle from valid inputs, the priority state and the wait counter. At most one `reqN_ready` is high. `ready` is never high without the matching `valid`.
- Default priority without the macro: port 1 wins a tie. Port 0 wins if `wait_cnt == MAX_WAIT`.
- `wait_cnt` (8-bit):
  - increments when `req0_valid` is high and port 0 is not granted; saturates at `MAX_WAIT`;
  - clears when port 0 is granted or `req0_valid` is low.
- Memory drive for the granted port:
  - both addresses take the granted address;
  - `memory_write_enable = reqN_write`;
  - data and mask are forwarded only for writes.
- Idle: all memory outputs are 0. Memory then performs a harmless read of address 0, and its result is ignored.
- Response tracking uses registered `resp_owner` (1 bit) and `resp_pending` (1 bit).
  - On accept, the owner is latched and pending is set; otherwise pending clears.
  - `respN_valid = resp_pending && resp_owner == N`.
- Write responses are acknowledge only. `rdata` is don't-care for writes, because memory holds stale data when it writes.
- Requesters must hold valid, address, data and mask stable until ready. The arbiter does not buffer requests.
- Back-to-back transactions are fully pipelined. A new grant may occur in the same cycle a response is delivered, giving 1 transaction per cycle peak.

## Timing
- Reset values: `resp_pending = 0`, `resp_owner = 0`, `wait_cnt = 0`, priority pointer = port 0 favoured.
- While `reset_n = 0`, both `ready` outputs and `memory_write_enable` are forced to 0.
- Read accepted in cycle N → `respN_valid = 1` and `rdata` valid in cycle N+1 only (single-cycle pulse).
- Write accepted in cycle N → memory is written at the end of cycle N, and `respN_valid` pulses in N+1.
- Read-after-write to the same word in consecutive cycles returns the new data.
- Reset asserted mid-transaction: the pending response is dropped and no `resp_valid` is issued after deassertion.
- Saturation: when `wait_cnt == MAX_WAIT` and both ports are valid, port 0 is granted and the counter clears the next cycle.

## Configuration
- `MEMORY_ARBITER_ROUND_ROBIN_EN` defined:
  - a 1-bit priority pointer flips to the non-granted port after every grant;
  - ties go to the pointed port;
  - `wait_cnt` logic is still present but can never reach `MAX_WAIT` for `MAX_WAIT >= 2`.
- Undefined: fixed priority with port 1 favoured, plus the starvation counter.

## Test plan
- Port 0 reads 0x80000000 (memory holds 0x00000013), port 1 idle → `req0_ready` high in cycle N; `resp0_valid` high and `resp0_rdata` = 0x00000013 in N+1 only.
- Port 1 writes 0xDEADBEEF to 0x80000100 with mask 0xFFFFFFFF in cycle N, then port 1 reads the same address in N+1 → `resp1_valid` in N+1 (write ack), `resp1_valid` in N+2 with `rdata` = 0xDEADBEEF.
- Both ports continuously valid, macro undefined, `MAX_WAIT` = 3 → port 1 granted 3 cycles, port 0 on the 4th; pattern 1,1,1,0 repeats.
- Both ports continuously valid, macro defined → grants alternate 0,1,0,1 starting with port 0 after reset.
- Read accepted in cycle N, `reset_n` low in N+1 → no `resp0_valid` at any time after; all outputs 0 during reset.
- Idle cycles (no valid) → `memory_write_enable` = 0, addresses 0, no `resp_valid`, `wait_cnt` stays 0.
